// File: rtl/sound_scheduler_if.sv
// sound_scheduler_if -- bundle of the request, ROM and codec signals around
// the sound scheduler.
//   req         requester -> scheduler, level request per animation
//   stop        requester -> scheduler, single-cycle abort pulse
//   rd_wr_en    codec -> scheduler, one sample consumed this cycle
//   rom_q       ROM -> scheduler, sample data (1-cycle read latency)
//   rom_addr    scheduler -> ROM, shared sound-ROM address
//   grant       scheduler -> requesters, one-hot grant, zero when idle
//   busy        scheduler -> requesters, clip in progress
//   done        scheduler -> requesters, one-cycle clip-completion pulse
//   wdata_left  scheduler -> codec, left-channel sample
//   wdata_right scheduler -> codec, right-channel sample (same as left)
// Modports: master = environment (requesters/ROM/codec), slave = scheduler.
interface sound_scheduler_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 17,
  parameter int unsigned DATA_W  = 24
);
  logic [NUM_REQ-1:0] req;
  logic               stop;
  logic               rd_wr_en;
  logic [DATA_W-1:0]  rom_q;
  logic [ADDR_W-1:0]  rom_addr;
  logic [NUM_REQ-1:0] grant;
  logic               busy;
  logic               done;
  logic [DATA_W-1:0]  wdata_left;
  logic [DATA_W-1:0]  wdata_right;

  modport master (
    output req, stop, rd_wr_en, rom_q,
    input  rom_addr, grant, busy, done, wdata_left, wdata_right
  );

  modport slave (
    input  req, stop, rd_wr_en, rom_q,
    output rom_addr, grant, busy, done, wdata_left, wdata_right
  );
endinterface

// File: rtl/sound_scheduler.sv
// sound_scheduler -- arbitrates NUM_REQ animation requesters round-robin onto
// one shared sound ROM and streams the granted clip (CLIP_LEN samples) to the
// codec, one sample per rd_wr_en.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    sound_scheduler_if.slave (req, stop, rd_wr_en, rom_q in;
//          rom_addr, grant, busy, done, wdata_left, wdata_right out)
// Optional feature: define SOUND_SCHEDULER_LOOP_EN to replay a clip without
// rearbitration while its requester still holds req at clip end.
module sound_scheduler #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned CLIP_LEN = 24000,
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned DATA_W   = 24
) (
  input logic             clk,
  input logic             reset,
  sound_scheduler_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned OFF_W = (CLIP_LEN > 1) ? $clog2(CLIP_LEN) : 1;
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(CLIP_LEN - 1);
  localparam longint unsigned SPAN = longint'(NUM_REQ) * longint'(CLIP_LEN);

  // All clips must be addressable within ADDR_W bits.
  if (SPAN > (64'd1 << ADDR_W)) begin : g_span_check
    $error("sound_scheduler: NUM_REQ*CLIP_LEN does not fit in ADDR_W bits");
  end

  typedef enum logic [1:0] {IDLE, PRIME, PLAY} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [OFF_W-1:0]   off_q, off_d;
  logic               done_q, done_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;
  logic [ADDR_W-1:0]  win_base;

  // Round-robin search starting just after the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((32'(last_q) + i) % NUM_REQ);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_base = ADDR_W'(win_idx) * ADDR_W'(CLIP_LEN);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    base_d  = base_q;
    addr_d  = addr_q;
    off_d   = off_q;
    done_d  = 1'b0;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = NUM_REQ'(1) << win_idx;
          last_d  = win_idx;
          base_d  = win_base;
          addr_d  = win_base;
          off_d   = '0;
          state_d = PRIME;
        end
      end
      PRIME: begin
        if (bus.stop) begin
          state_d = IDLE;
          grant_d = '0;
          done_d  = 1'b1;
        end else begin
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (bus.stop) begin
          state_d = IDLE;
          grant_d = '0;
          done_d  = 1'b1;
        end else if (bus.rd_wr_en) begin
          wdata_d = bus.rom_q;
          if (off_q == LAST_OFF) begin
            // Address stays on the final sample so it never leaves the clip.
            done_d = 1'b1;
`ifdef SOUND_SCHEDULER_LOOP_EN
            if (bus.req[last_q]) begin
              addr_d  = base_q;
              off_d   = '0;
              state_d = PRIME;
            end else begin
              state_d = IDLE;
              grant_d = '0;
            end
`else
            state_d = IDLE;
            grant_d = '0;
`endif
          end else begin
            off_d  = off_q + 1'b1;
            addr_d = addr_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      base_q  <= '0;
      addr_q  <= '0;
      off_q   <= '0;
      done_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      done_q  <= done_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.rom_addr    = addr_q;
  assign bus.grant       = grant_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.wdata_left  = wdata_q;
  assign bus.wdata_right = wdata_q;

endmodule

// File: tb/tb_sound_scheduler.sv
// tb_sound_scheduler -- directed bench for sound_scheduler with a clip-level
// reference model compared every cycle, plus hand-computed spot checks.
module tb_sound_scheduler;
  localparam int NUM_REQ  = 4;
  localparam int CLIP_LEN = 24000;
  localparam int ADDR_W   = 17;
  localparam int DATA_W   = 24;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sound_scheduler_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sound_scheduler #(
    .NUM_REQ(NUM_REQ), .CLIP_LEN(CLIP_LEN), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

`ifdef SOUND_SCHEDULER_LOOP_EN
  bit loop_en = 1'b1;
`else
  bit loop_en = 1'b0;
`endif

  function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
    return (DATA_W'(a) * DATA_W'(37)) ^ DATA_W'(24'h5A5A5A);
  endfunction

  // Sound ROM with one cycle of read latency.
  always @(posedge clk) bus.rom_q <= rom_fn(bus.rom_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Clip-level model: which requester owns the ROM, where in its clip it is,
  // and what the codec was last handed.
  int m_phase = 0;          // 0 idle, 1 waiting for ROM, 2 streaming
  int m_win   = -1;
  int m_last  = NUM_REQ - 1;
  int m_off   = 0;
  int m_addr  = 0;
  bit m_done  = 1'b0;
  logic [DATA_W-1:0] m_wd = '0;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_phase = 0; m_win = -1; m_last = NUM_REQ - 1;
      m_off = 0; m_addr = 0; m_done = 1'b0; m_wd = '0;
    end else begin
      m_done = 1'b0;
      if (m_phase == 0) begin
        for (int i = 1; i <= NUM_REQ; i++) begin
          int w;
          w = (m_last + i) % NUM_REQ;
          if (bus.req[w]) begin
            m_win = w; m_last = w; m_addr = w * CLIP_LEN; m_off = 0; m_phase = 1;
            break;
          end
        end
      end else if (bus.stop) begin
        m_phase = 0; m_win = -1; m_done = 1'b1;
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (bus.rd_wr_en) begin
        m_wd = bus.rom_q;
        if (m_off == CLIP_LEN - 1) begin
          m_done = 1'b1;
          if (loop_en && bus.req[m_win]) begin
            m_addr = m_win * CLIP_LEN; m_off = 0; m_phase = 1;
          end else begin
            m_phase = 0; m_win = -1;
          end
        end else begin
          m_off++; m_addr++;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    logic [NUM_REQ-1:0] eg;
    @(posedge clk);
    #1;
    eg = (m_win < 0) ? '0 : (NUM_REQ'(1) << m_win);
    check("grant", bus.grant, eg);
    check("busy", bus.busy, m_phase != 0);
    check("done", bus.done, m_done);
    check("rom_addr", bus.rom_addr, m_addr);
    check("wdata_left", bus.wdata_left, m_wd);
    check("wdata_right", bus.wdata_right, m_wd);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.req = '0; bus.stop = 1'b0; bus.rd_wr_en = 1'b0;
    @(negedge clk);
    check("rst_grant", bus.grant, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_addr", bus.rom_addr, 0);
    check("rst_wdata", bus.wdata_left, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
  endtask

  task automatic wait_grant(output int waited);
    waited = -1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (bus.grant != 0) begin
        waited = n;
        break;
      end
    end
    if (waited < 0) begin
      errors++;
      $display("FAIL wait_grant: no grant within 8 cycles at %0t", $time);
    end
  endtask

  task automatic wait_addr(input int target, input int limit);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < limit; n++) begin
      tick();
      if (bus.rom_addr == target) begin
        hit = 1'b1;
        break;
      end
    end
    check("wait_addr_reached", hit, 1);
  endtask

  initial begin
    int done_at;
    int waited;
    int exp_g[5];
    int exp_b[5];
    logic [ADDR_W-1:0] prev_addr;
    logic [DATA_W-1:0] prev_wd;
    logic [DATA_W-1:0] ew;
    bit rd;

    bus.req = '0; bus.stop = 1'b0; bus.rd_wr_en = 1'b0;
    exp_g = '{1, 2, 4, 8, 1};
    exp_b = '{0, 24000, 48000, 72000, 0};

    // 1: single requester, codec always ready, full clip.
    do_reset();
    @(negedge clk);
    bus.req = 4'b0001; bus.rd_wr_en = 1'b1;
    tick();
    check("s1_grant", bus.grant, 4'b0001);
    check("s1_addr_prime", bus.rom_addr, 0);
    @(negedge clk);
    bus.req = '0;  // dropping req must not end the clip
    tick();
    check("s1_addr_play0", bus.rom_addr, 0);
    tick();
    check("s1_addr_1", bus.rom_addr, 1);
    ew = rom_fn(0);
    check("s1_first_sample", bus.wdata_left, ew);
    tick();
    check("s1_addr_2", bus.rom_addr, 2);
    done_at = -1;
    for (int n = 4; n <= 24010; n++) begin
      tick();
      if (bus.done) begin
        done_at = n;
        break;
      end
    end
    check("s1_done_cycle", done_at, 24001);
    check("s1_last_addr", bus.rom_addr, 23999);
    check("s1_grant_clear", bus.grant, 0);

    // 2: all requesting, round-robin order and clip bases.
    do_reset();
    @(negedge clk);
    bus.req = 4'b1111; bus.rd_wr_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_grant(waited);
      if (k > 0) check("s2_idle_gap", waited, 1);
      check("s2_grant", bus.grant, exp_g[k]);
      check("s2_base", bus.rom_addr, exp_b[k]);
      repeat (5) tick();
      pulse_stop();
    end

    // 3: codec ready toggling during PLAY.
    do_reset();
    @(negedge clk);
    bus.req = 4'b0001; bus.rd_wr_en = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      rd = (k % 2 == 0);
      bus.rd_wr_en = rd;
      prev_addr = bus.rom_addr;
      prev_wd = bus.wdata_left;
      tick();
      check("s3_addr_step", bus.rom_addr, prev_addr + ADDR_W'(rd));
      if (!rd) check("s3_wdata_hold", bus.wdata_left, prev_wd);
      check("s3_lr_equal", bus.wdata_right, bus.wdata_left);
    end
    @(negedge clk);
    bus.req = '0;
    pulse_stop();

    // 4: stop at offset 100 of clip 2.
    do_reset();
    @(negedge clk);
    bus.req = 4'b0100; bus.rd_wr_en = 1'b1;
    wait_addr(48100, 200);
    @(negedge clk);
    bus.stop = 1'b1;
    tick();
    check("s4_stop_busy", bus.busy, 0);
    check("s4_stop_grant", bus.grant, 0);
    check("s4_stop_done", bus.done, 1);
    @(negedge clk);
    bus.stop = 1'b0;
    tick();
    check("s4_regrant_2", bus.grant, 4'b0100);
    wait_addr(48100, 200);
    @(negedge clk);
    bus.req = 4'b1100; bus.stop = 1'b1;
    tick();
    check("s4_stop2_done", bus.done, 1);
    @(negedge clk);
    bus.stop = 1'b0;
    tick();
    check("s4_grant_3", bus.grant, 4'b1000);
    check("s4_base_3", bus.rom_addr, 72000);

    // 5: asynchronous reset between edges mid-PLAY.
    repeat (4) tick();
    #2;
    reset = 1'b1;
    #1;
    check("s5_async_grant", bus.grant, 0);
    check("s5_async_busy", bus.busy, 0);
    check("s5_async_done", bus.done, 0);
    check("s5_async_addr", bus.rom_addr, 0);
    check("s5_async_wdata", bus.wdata_right, 0);
    @(negedge clk);
    reset = 1'b0; bus.req = 4'b0010; bus.rd_wr_en = 1'b1; bus.stop = 1'b0;
    tick();
    check("s5_grant", bus.grant, 4'b0010);
    check("s5_base", bus.rom_addr, 24000);
`ifdef SOUND_SCHEDULER_LOOP_EN
    done_at = -1;
    for (int n = 1; n <= 24010; n++) begin
      tick();
      if (bus.done) begin
        done_at = n;
        break;
      end
    end
    check("s5_loop_done_cycle", done_at, 24001);
    check("s5_loop_grant", bus.grant, 4'b0010);
    check("s5_loop_busy", bus.busy, 1);
    check("s5_loop_reload", bus.rom_addr, 24000);
    tick();
    check("s5_loop_play", bus.rom_addr, 24000);
    tick();
    check("s5_loop_adv", bus.rom_addr, 24001);
`else
    repeat (10) tick();
`endif
    @(negedge clk);
    bus.req = '0;
    pulse_stop();
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not end, got time %0t required below 2000000", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/sound_scheduler.md
SOUND_SCHEDULER -- requirements
Module: sound_scheduler

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
  NUM_REQ  4      number of animation requesters
  CLIP_LEN 24000  samples per clip
  ADDR_W   17     shared sound-ROM address width
  DATA_W   24     sample width
REQ-002 Ports (name  direction  width  meaning) SHALL be:
  clk          in   1        system clock
  reset        in   1        asynchronous, active-high reset
  req          in   NUM_REQ  level request to play clip i, one bit per animation
  stop         in   1        single-cycle pulse that aborts the current clip
  rd_wr_en     in   1        codec ready, meaning one sample is consumed this cycle
  rom_q        in   DATA_W   shared ROM data, 1-cycle read latency
  rom_addr     out  ADDR_W   shared ROM address
  grant        out  NUM_REQ  one-hot grant; all-zero when idle
  busy         out  1        high while a clip is being sequenced
  done         out  1        one-cycle pulse at clip completion
  wdata_left   out  DATA_W   left-channel sample
  wdata_right  out  DATA_W   right-channel sample, always equal to wdata_left

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, PRIME and PLAY.
REQ-004 IDLE: if any req bit is high, the block SHALL select a winner round-robin, starting the search at (last winner + 1) mod NUM_REQ, then register grant, load rom_addr = winner*CLIP_LEN and go to PRIME.
REQ-005 PRIME SHALL last exactly one cycle, covering the ROM latency, then go to PLAY; rd_wr_en SHALL be ignored in PRIME.
REQ-006 PLAY, cycle with rd_wr_en high: wdata_left and wdata_right SHALL register rom_q, the sample offset SHALL increment and rom_addr SHALL advance by 1.
REQ-007 PLAY, cycle with rd_wr_en low: rom_addr, the sample offset and the outputs SHALL all hold.
REQ-008 When a sample is consumed at offset CLIP_LEN-1, the block SHALL pulse done for 1 cycle, clear grant and return to IDLE; rom_addr SHALL never leave the range [base, base+CLIP_LEN-1].
REQ-009 stop in PRIME or PLAY SHALL take priority over rd_wr_en: return to IDLE next cycle, clear grant and pulse done.
REQ-010 stop in IDLE SHALL be ignored.
REQ-011 A granted requester dropping req mid-clip SHALL NOT abort the clip; only stop or clip end ends it.
REQ-012 Grant SHALL change only from IDLE; there SHALL be no preemption.
REQ-013 The minimum gap between one clip's end and the next clip's first consumed sample SHALL be 2 cycles (IDLE, PRIME).
REQ-014 busy SHALL equal (state != IDLE).
REQ-015 Address arithmetic SHALL be unsigned ADDR_W bits; NUM_REQ*CLIP_LEN SHALL fit in ADDR_W bits, and this SHALL be checked at elaboration.

Reset
REQ-016 reset SHALL act asynchronously, regardless of state: state=IDLE, rom_addr=0, offset=0, grant=0, busy=0, done=0, wdata_left=wdata_right=0, last winner=NUM_REQ-1 (so requester 0 wins first).
REQ-017 After reset deasserts, the first arbitration SHALL occur on the first clk edge that sees req nonzero.

Configuration
REQ-018 With macro SOUND_SCHEDULER_LOOP_EN defined: at clip end, if the granted requester's req bit is still high, the block SHALL pulse done, reload rom_addr=base, keep grant and go to PRIME without rearbitration.
REQ-019 With SOUND_SCHEDULER_LOOP_EN undefined: clip end SHALL always return to IDLE per REQ-008.

Verification
REQ-020 The bench SHALL cover at least these five scenarios:
  1. reset; req=0001; rd_wr_en=1 continuously -> grant=0001, rom_addr 0,0,1,2..., done pulses exactly 24001 cycles after PRIME entry, last rom_addr=23999.
  2. req=1111 held, loop disabled -> grants in order 0001,0010,0100,1000,0001; rom_addr bases 0,24000,48000,72000.
  3. rd_wr_en toggling 1,0 each cycle during PLAY -> rom_addr advances only on rd_wr_en=1 cycles; wdata holds on 0 cycles; wdata_left==wdata_right always.
  4. stop pulse at offset 100 of clip 2 -> next cycle IDLE, grant=0, done=1; with req=0100 still high the next grant is 1000 if req[3] is set, else 0100.
  5. reset asserted mid-PLAY between clk edges -> all outputs 0 immediately; with SOUND_SCHEDULER_LOOP_EN and req=0010 held, clip 1 replays from rom_addr=24000 after a done pulse, grant stays 0010.
